dca_lsu_wdata_packer: RTL and testbench
=======================================

DCA_LSU_WDATA_PACKER -- requirements
Module: dca_lsu_wdata_packer

Interface
REQ-001 The block SHALL have the parameter BW_AXI_DATA, default 32, meaning the AXI W data width; legal values are 32, 64, 128 and 256.
REQ-002 The block SHALL have the parameter ROW_BEATS, default 4, meaning the number of AXI beats per tensor row (1..8); BW_ROW = ROW_BEATS*BW_AXI_DATA.
REQ-003 The block SHALL have the parameter TXN_DEPTH, default 4, meaning the depth of the burst-length FIFO (power of 2, 2..16).
REQ-004 The block SHALL have the parameter MAX_OUTSTANDING, default 8, meaning the limit on bursts awaiting a B response (1..255).
REQ-005 The block SHALL use a single clock: clk, input, 1 bit, rising edge.
REQ-006 The block SHALL have rstnn, input, 1 bit, an asynchronous active-low reset.
REQ-007 The block SHALL have clear, input, 1 bit, a synchronous flush.
REQ-008 The block SHALL have busy, output, 1 bit, meaning a row is held, a burst is pending or a burst is outstanding.
REQ-009 The block SHALL have err_flag, output, 1 bit, a sticky flag for a non-OKAY BRESP.
REQ-010 The block SHALL have the burst-request ports txn_valid (in, 1), txn_ready (out, 1) and txn_len (in, 8), where burst beats = txn_len+1.
REQ-011 The block SHALL have the row-input ports row_valid (in, 1), row_ready (out, 1), row_data (in, BW_ROW) and row_bytes (in, clog2(BW_ROW/8)+1), where row_bytes is the number of valid bytes, 1..BW_ROW/8.
REQ-012 The block SHALL have the W-channel ports wvalid (out, 1), wready (in, 1), wdata (out, BW_AXI_DATA), wstrb (out, BW_AXI_DATA/8) and wlast (out, 1).
REQ-013 The block SHALL have the B-channel ports bvalid (in, 1), bready (out, 1) and bresp (in, 2).

Function
REQ-014 Row FSM states SHALL be: IDLE (no row held) and EMIT (row held, beat index k).
- IDLE->EMIT on a row handshake.
- EMIT->IDLE on the last-beat handshake with no new row.
- EMIT->EMIT on the last beat plus a simultaneous new row.
REQ-015 row_ready SHALL equal (state==IDLE) or (last beat of the held row handshakes this cycle), giving back-to-back rows with no bubble.
REQ-016 Row latency SHALL be one cycle: a row accepted in cycle N presents its first beat in cycle N+1.
REQ-017 A row SHALL occupy ceil(row_bytes/(BW_AXI_DATA/8)) beats; beat k SHALL carry wdata = row_data[k*BW_AXI_DATA +: BW_AXI_DATA].
REQ-018 wstrb SHALL be all ones for a full beat; on the last partial beat its low (remaining bytes) bits SHALL be set.
REQ-019 wvalid SHALL equal (state==EMIT) and (burst FIFO non-empty) and (outstanding < MAX_OUTSTANDING).
REQ-020 While wvalid=1 and wready=0, wdata, wstrb and wlast SHALL hold stable.
REQ-021 The burst FIFO SHALL store txn_len; txn_ready SHALL equal FIFO not full.
REQ-022 A burst beat counter SHALL count W handshakes; wlast SHALL be 1 when counter == head txn_len.
- On a wlast handshake the FIFO SHALL pop, the counter SHALL reset to 0, and outstanding SHALL increment.
REQ-023 Row and burst boundaries SHALL be independent: a row may straddle two bursts, and a burst may span several rows.
REQ-024 bready SHALL be constantly 1; each bvalid SHALL decrement outstanding.
- A simultaneous increment and decrement SHALL leave outstanding unchanged.
- bvalid with outstanding==0 SHALL be ignored.
REQ-025 bresp != 2'b00 on a bvalid SHALL set err_flag, which holds until clear or reset.
REQ-026 busy SHALL equal (state==EMIT) or (FIFO non-empty) or (outstanding != 0).
REQ-027 clear=1 SHALL, on the next edge:
- force IDLE;
- empty the FIFO;
- zero the beat and burst counters, outstanding and err_flag.
- clear SHALL take priority over every simultaneous handshake.
- clear is software's responsibility after an abort; the block SHALL NOT protect in-flight AXI beats.

Reset
REQ-028 On rstnn=0 all state SHALL reset asynchronously to IDLE/empty/zero.
- Output values during and after reset: wvalid=0, wlast=0, wdata=0, wstrb=0, row_ready=1, txn_ready=1, bready=1, busy=0, err_flag=0.
REQ-029 Reset asserted mid-row or mid-burst SHALL discard all data; no beat SHALL be emitted after reset until a new txn and a new row are accepted.

Structure
REQ-030 The FSM state encoding and the AXI BRESP OKAY constant SHALL live in the shared dca LSU package/include.
- The beat-count function ceil(row_bytes/bytes-per-beat) SHALL also live there.
REQ-031 The burst-length FIFO SHALL be one sub-module, dca_lsu_txn_fifo (parameters: width and depth); the rest of the block is flat.

Verification (BW_AXI_DATA=32, ROW_BEATS=4, MAX_OUTSTANDING=2)
REQ-032 txn_len=3; row_bytes=16, data 0x33333333_22222222_11111111_00000000, wready=1 -> beats 0x00000000..0x33333333 in cycles N+1..N+4, wstrb=F each, wlast only on beat 4.
REQ-033 txn_len=1; row_bytes=6 -> 2 beats, wstrb F then 3, wlast on beat 2.
REQ-034 txns len 2 and len 2; three rows of 8 bytes each (6 beats) -> wlast on beats 3 and 6; the second row straddles the bursts with no bubble.
REQ-035 wready toggled 0/1 pseudo-randomly during REQ-032 -> same 4 beats in order, payload stable during every stall, no beat lost or duplicated.
REQ-036 Three 1-beat bursts with B withheld:
- wvalid SHALL drop after 2 bursts;
- one bvalid with bresp=2'b10 SHALL release the third burst and set err_flag;
- err_flag SHALL stay set until clear.
REQ-037 rstnn pulsed low during beat 2 of REQ-032 -> wvalid=0 immediately, busy=0; a new txn and row then produce a correct 4-beat burst.

Source files
------------

// File: rtl/dca_lsu_wdata_packer_pkg.sv
// Shared definitions for the LSU write-data packer: row FSM encoding, AXI constants, beat math.
package dca_lsu_wdata_packer_pkg;

    typedef enum logic {
        ROW_IDLE = 1'b0,
        ROW_EMIT = 1'b1
    } row_state_e;

    localparam logic [1:0]  AXI_BRESP_OKAY = 2'b00;
    localparam int unsigned TXN_LEN_W      = 8;

    // Number of W beats needed to carry nbytes at bytes_per_beat (ceiling division).
    function automatic int unsigned beat_count(input int unsigned nbytes,
                                               input int unsigned bytes_per_beat);
        return (nbytes + bytes_per_beat - 1) / bytes_per_beat;
    endfunction

endpackage

// File: rtl/dca_lsu_txn_fifo.sv
// Small synchronous FIFO holding AXI burst lengths awaiting their W beats.
module dca_lsu_txn_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem[rd_ptr_q[AW-1:0]];

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dca_lsu_wdata_packer.sv
// Slices tensor rows into AXI W beats, framing them into bursts and tracking B responses.
module dca_lsu_wdata_packer
    import dca_lsu_wdata_packer_pkg::*;
#(
    parameter int unsigned BW_AXI_DATA     = 32,
    parameter int unsigned ROW_BEATS       = 4,
    parameter int unsigned TXN_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 8,
    localparam int unsigned BW_ROW         = ROW_BEATS * BW_AXI_DATA,
    localparam int unsigned BPB            = BW_AXI_DATA / 8,
    localparam int unsigned ROW_BYTES_W    = $clog2(BW_ROW / 8) + 1
) (
    input  logic                   clk,
    input  logic                   rstnn,
    input  logic                   clear,
    output logic                   busy,
    output logic                   err_flag,
    input  logic                   txn_valid,
    output logic                   txn_ready,
    input  logic [TXN_LEN_W-1:0]   txn_len,
    input  logic                   row_valid,
    output logic                   row_ready,
    input  logic [BW_ROW-1:0]      row_data,
    input  logic [ROW_BYTES_W-1:0] row_bytes,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [BW_AXI_DATA-1:0] wdata,
    output logic [BPB-1:0]         wstrb,
    output logic                   wlast,
    input  logic                   bvalid,
    output logic                   bready,
    input  logic [1:0]             bresp
);

    localparam int unsigned KW    = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam int unsigned OUT_W = 8;

    row_state_e                                  state_q;
    row_state_e                                  state_d;
    logic [ROW_BEATS-1:0][BW_AXI_DATA-1:0]       row_q;
    logic [KW-1:0]                               beat_k_q;
    logic [KW-1:0]                               last_k_q;
    logic [KW-1:0]                               last_k_d;
    logic [BPB-1:0]                              tail_strb_q;
    logic [BPB-1:0]                              tail_strb_d;
    logic [TXN_LEN_W-1:0]                        burst_cnt_q;
    logic [OUT_W-1:0]                            outst_q;
    logic                                        err_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [TXN_LEN_W-1:0] fifo_head;
    logic                 row_last;
    logic                 w_hs;
    logic                 row_hs;
    logic                 burst_done;
    logic                 b_take;

    // Burst-length queue: one entry per requested burst, popped on its wlast.
    dca_lsu_txn_fifo #(
        .WIDTH (TXN_LEN_W),
        .DEPTH (TXN_DEPTH)
    ) u_txn_fifo (
        .clk       (clk),
        .rstnn     (rstnn),
        .clear     (clear),
        .push      (txn_valid),
        .push_data (txn_len),
        .pop       (burst_done),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign row_last   = (beat_k_q == last_k_q);
    assign wvalid     = (state_q == ROW_EMIT) && !fifo_empty && (outst_q < OUT_W'(MAX_OUTSTANDING));
    assign w_hs       = wvalid && wready;
    assign wlast      = wvalid && (burst_cnt_q == fifo_head);
    assign burst_done = w_hs && wlast;
    assign row_ready  = (state_q == ROW_IDLE) || (w_hs && row_last);
    assign row_hs     = row_valid && row_ready;
    assign b_take     = bvalid && (outst_q != '0);
    assign wdata      = (state_q == ROW_EMIT) ? row_q[beat_k_q] : '0;
    assign wstrb      = (state_q == ROW_EMIT) ? (row_last ? tail_strb_q : '1) : '0;
    assign txn_ready  = !fifo_full;
    assign bready     = 1'b1;
    assign err_flag   = err_q;
    assign busy       = (state_q == ROW_EMIT) || !fifo_empty || (outst_q != '0);

    // Geometry of the incoming row: index of its last beat and strobe mask for that beat.
    always_comb begin
        int unsigned nbeats;
        int unsigned tail;
        nbeats      = beat_count(32'(row_bytes), BPB);
        tail        = 32'(row_bytes) - (nbeats - 1) * BPB;
        last_k_d    = KW'(nbeats - 1);
        tail_strb_d = '0;
        for (int unsigned i = 0; i < BPB; i++) begin
            tail_strb_d[i] = (i < tail);
        end
    end

    // Row FSM state register.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q <= ROW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Row FSM next state: a new row may be taken in the same cycle the old one finishes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ROW_IDLE: begin
                if (row_hs) begin
                    state_d = ROW_EMIT;
                end
            end
            ROW_EMIT: begin
                if (w_hs && row_last) begin
                    state_d = row_valid ? ROW_EMIT : ROW_IDLE;
                end
            end
            default: state_d = ROW_IDLE;
        endcase
        if (clear) begin
            state_d = ROW_IDLE;
        end
    end

    // Held row payload and per-row beat index.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            row_q       <= '0;
            beat_k_q    <= '0;
            last_k_q    <= '0;
            tail_strb_q <= '0;
        end else if (clear) begin
            beat_k_q <= '0;
        end else if (row_hs) begin
            row_q       <= row_data;
            beat_k_q    <= '0;
            last_k_q    <= last_k_d;
            tail_strb_q <= tail_strb_d;
        end else if (w_hs) begin
            beat_k_q <= beat_k_q + KW'(1);
        end
    end

    // Burst beat counter, outstanding-burst count and sticky error flag.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            burst_cnt_q <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
        end else if (clear) begin
            burst_cnt_q <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (burst_done) begin
                burst_cnt_q <= '0;
            end else if (w_hs) begin
                burst_cnt_q <= burst_cnt_q + TXN_LEN_W'(1);
            end
            case ({burst_done, b_take})
                2'b10:   outst_q <= outst_q + OUT_W'(1);
                2'b01:   outst_q <= outst_q - OUT_W'(1);
                default: outst_q <= outst_q;
            endcase
            if (b_take && (bresp != AXI_BRESP_OKAY)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dca_lsu_wdata_packer.sv
// Directed self-checking bench for the LSU write-data packer (32-bit W, 4-beat rows, 2 outstanding).
module tb_dca_lsu_wdata_packer;

    logic         clk;
    logic         rstnn;
    logic         clear;
    logic         busy;
    logic         err_flag;
    logic         txn_valid;
    logic         txn_ready;
    logic [7:0]   txn_len;
    logic         row_valid;
    logic         row_ready;
    logic [127:0] row_data;
    logic [4:0]   row_bytes;
    logic         wvalid;
    logic         wready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         bvalid;
    logic         bready;
    logic [1:0]   bresp;

    int tests = 0;
    int fails = 0;
    int cyc_used;

    logic [127:0] r_data  [4];
    logic [4:0]   r_bytes [4];
    logic [7:0]   t_len   [4];
    logic [31:0]  e_data  [8];
    logic [3:0]   e_strb  [8];
    logic         e_last  [8];

    dca_lsu_wdata_packer #(
        .BW_AXI_DATA     (32),
        .ROW_BEATS       (4),
        .TXN_DEPTH       (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk       (clk),
        .rstnn     (rstnn),
        .clear     (clear),
        .busy      (busy),
        .err_flag  (err_flag),
        .txn_valid (txn_valid),
        .txn_ready (txn_ready),
        .txn_len   (txn_len),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_bytes (row_bytes),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Feed rows/txns from the tables, apply the wready pattern and check each presented beat.
    task automatic run(input int n_rows, input int n_txns, input int n_beats,
                       input logic [31:0] pat, input string tag, output int cycles);
        int ri = 0;
        int ti = 0;
        int bi = 0;
        int cyc = 0;
        while (bi < n_beats && cyc < 100) begin
            @(negedge clk);
            row_valid = (ri < n_rows);
            row_data  = r_data[ri % 4];
            row_bytes = r_bytes[ri % 4];
            txn_valid = (ti < n_txns);
            txn_len   = t_len[ti % 4];
            wready    = pat[cyc % 32];
            #1;
            if (wvalid) begin
                chk($sformatf("%s_data%0d", tag, bi), wdata, e_data[bi]);
                chk($sformatf("%s_strb%0d", tag, bi), wstrb, e_strb[bi]);
                chk($sformatf("%s_last%0d", tag, bi), wlast, e_last[bi]);
            end
            if (row_valid && row_ready) ri++;
            if (txn_valid && txn_ready) ti++;
            if (wvalid && wready) bi++;
            cyc++;
        end
        chk($sformatf("%s_beats", tag), bi, n_beats);
        @(posedge clk);
        #1;
        row_valid = 1'b0;
        txn_valid = 1'b0;
        cycles = cyc;
    endtask

    task automatic b_resp(input logic [1:0] r);
        @(negedge clk);
        bvalid = 1'b1;
        bresp  = r;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
    endtask

    task automatic setup_full_row();
        r_data[0]  = 128'h33333333_22222222_11111111_00000000;
        r_bytes[0] = 5'd16;
        t_len[0]   = 8'd3;
        e_data[0] = 32'h00000000; e_data[1] = 32'h11111111;
        e_data[2] = 32'h22222222; e_data[3] = 32'h33333333;
        for (int i = 0; i < 4; i++) begin
            e_strb[i] = 4'hF;
            e_last[i] = (i == 3);
        end
    endtask

    initial begin
        rstnn = 1'b0; clear = 1'b0;
        txn_valid = 1'b0; txn_len = '0;
        row_valid = 1'b0; row_data = '0; row_bytes = '0;
        wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_wlast", wlast, 1'b0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_wstrb", wstrb, 4'h0);
        chk("rst_row_ready", row_ready, 1'b1);
        chk("rst_txn_ready", txn_ready, 1'b1);
        chk("rst_bready", bready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_flag, 1'b0);
        @(negedge clk);
        rstnn = 1'b1;

        // Full 16-byte row in one 4-beat burst
        setup_full_row();
        run(1, 1, 4, 32'hFFFF_FFFF, "full", cyc_used);
        chk("full_cycles", cyc_used, 5);
        @(negedge clk);
        #1;
        chk("full_idle_wvalid", wvalid, 1'b0);
        chk("full_busy_outst", busy, 1'b1);
        b_resp(2'b00);
        #1;
        chk("full_busy_done", busy, 1'b0);
        chk("full_err", err_flag, 1'b0);

        // Partial row: 6 bytes in a 2-beat burst
        r_data[0]  = 128'hFFFFFFFF_EEEEEEEE_DDCCBBAA_44332211;
        r_bytes[0] = 5'd6;
        t_len[0]   = 8'd1;
        e_data[0] = 32'h44332211; e_strb[0] = 4'hF; e_last[0] = 1'b0;
        e_data[1] = 32'hDDCCBBAA; e_strb[1] = 4'h3; e_last[1] = 1'b1;
        run(1, 1, 2, 32'hFFFF_FFFF, "part", cyc_used);
        b_resp(2'b00);
        #1;
        chk("part_busy_done", busy, 1'b0);

        // Three 8-byte rows across two 3-beat bursts, no bubble
        r_data[0] = 128'h0_A1A1A1A1_A0A0A0A0; r_bytes[0] = 5'd8;
        r_data[1] = 128'h0_B1B1B1B1_B0B0B0B0; r_bytes[1] = 5'd8;
        r_data[2] = 128'h0_C1C1C1C1_C0C0C0C0; r_bytes[2] = 5'd8;
        t_len[0] = 8'd2; t_len[1] = 8'd2;
        e_data[0] = 32'hA0A0A0A0; e_data[1] = 32'hA1A1A1A1;
        e_data[2] = 32'hB0B0B0B0; e_data[3] = 32'hB1B1B1B1;
        e_data[4] = 32'hC0C0C0C0; e_data[5] = 32'hC1C1C1C1;
        for (int i = 0; i < 6; i++) begin
            e_strb[i] = 4'hF;
            e_last[i] = (i == 2) || (i == 5);
        end
        run(3, 2, 6, 32'hFFFF_FFFF, "strad", cyc_used);
        chk("strad_cycles", cyc_used, 7);
        b_resp(2'b00);
        b_resp(2'b00);
        #1;
        chk("strad_busy_done", busy, 1'b0);

        // Full row again with wready stalls; payload must hold on each stall
        setup_full_row();
        run(1, 1, 4, 32'h6B5A_9C35, "stall", cyc_used);
        b_resp(2'b00);
        #1;
        chk("stall_busy_done", busy, 1'b0);

        // Three 1-beat bursts against an outstanding limit of two
        r_data[0]  = 128'h0_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        r_bytes[0] = 5'd12;
        t_len[0] = 8'd0; t_len[1] = 8'd0; t_len[2] = 8'd0;
        e_data[0] = 32'hAAAAAAAA; e_strb[0] = 4'hF; e_last[0] = 1'b1;
        e_data[1] = 32'hBBBBBBBB; e_strb[1] = 4'hF; e_last[1] = 1'b1;
        run(1, 3, 2, 32'hFFFF_FFFF, "lim", cyc_used);
        @(negedge clk);
        wready = 1'b1;
        #1;
        chk("lim_blocked", wvalid, 1'b0);
        chk("lim_busy", busy, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("lim_still_blocked", wvalid, 1'b0);
        @(negedge clk);
        bvalid = 1'b1;
        bresp  = 2'b10;
        #1;
        chk("lim_blocked_at_b", wvalid, 1'b0);
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        #1;
        chk("lim_err_set", err_flag, 1'b1);
        chk("lim_released", wvalid, 1'b1);
        chk("lim_data2", wdata, 32'hCCCCCCCC);
        chk("lim_last2", wlast, 1'b1);
        @(negedge clk);
        #1;
        chk("lim_done_wvalid", wvalid, 1'b0);
        chk("lim_err_hold", err_flag, 1'b1);
        b_resp(2'b00);
        b_resp(2'b00);
        #1;
        chk("lim_busy_done", busy, 1'b0);
        chk("lim_err_sticky", err_flag, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("lim_err_cleared", err_flag, 1'b0);

        // Reset asserted on the second beat of a burst
        setup_full_row();
        run(1, 1, 1, 32'hFFFF_FFFF, "rstmid", cyc_used);
        @(negedge clk);
        #1;
        chk("rstmid_beat2", wdata, 32'h11111111);
        chk("rstmid_beat2_valid", wvalid, 1'b1);
        rstnn = 1'b0;
        #1;
        chk("rstmid_wvalid", wvalid, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_wdata", wdata, 32'h0);
        chk("rstmid_row_ready", row_ready, 1'b1);
        @(negedge clk);
        rstnn = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rstmid_quiet", wvalid, 1'b0);
        run(1, 1, 4, 32'hFFFF_FFFF, "after_rst", cyc_used);
        chk("after_rst_cycles", cyc_used, 5);
        b_resp(2'b00);
        #1;
        chk("after_rst_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
